// File: rtl/dpu_result_collector_pkg.sv
// Shared types and constants for the DPU result collector: instruction
// field layout, buffer geometry and the capture controller state encoding.
package dpu_result_collector_pkg;

  localparam int BITWIDTH                  = 16;
  localparam int DEPTH                     = 16;
  localparam int ADDR_WIDTH                = $clog2(DEPTH);
  localparam int ITER_WIDTH                = 6;
  localparam int DELAY_WIDTH               = 3;
  localparam int INSTRUCTION_PAYLOAD_WIDTH = 27;
  localparam int OPCODE_H                  = 26;
  localparam int OPCODE_L                  = 24;
  localparam int COL_WIDTH                 = 24;
  localparam logic [2:0] OPCODE_COL        = 3'd5;

  // Collector configuration word, MSB-first below the opcode.
  typedef struct packed {
    logic [3:0]             _start;
    logic [3:0]             _step;
    logic [ITER_WIDTH-1:0]  _iter;
    logic [DELAY_WIDTH-1:0] _delay;
    logic [6:0]             _reserved;
  } col_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_GAP     = 2'd2,
    ST_FINISH  = 2'd3
  } state_t;

  function automatic col_t unpack_col(input logic [COL_WIDTH-1:0] payload);
    col_t c;
    c._start    = payload[23:20];
    c._step     = payload[19:16];
    c._iter     = payload[15:10];
    c._delay    = payload[9:7];
    c._reserved = payload[6:0];
    return c;
  endfunction

  function automatic logic [COL_WIDTH-1:0] pack_col(input col_t c);
    return {c._start, c._step, c._iter, c._delay, c._reserved};
  endfunction

endpackage

// File: rtl/dpu_result_collector_if.sv
// Bundle of the collector's instruction, capture, read and status signals.
// The master side is the instruction source / consumer; the slave side is
// the collector itself.
interface dpu_result_collector_if
  import dpu_result_collector_pkg::*;
();

  logic                                 instruction_valid;
  logic [INSTRUCTION_PAYLOAD_WIDTH-1:0] instruction;
  logic                                 activate;
  logic [BITWIDTH-1:0]                  data_in;
  logic                                 rd_en;
  logic [ADDR_WIDTH-1:0]                rd_addr;
  logic [BITWIDTH-1:0]                  rd_data;
  logic                                 rd_valid;
  logic                                 busy;
  logic                                 done;

  modport master (
    output instruction_valid, instruction, activate, data_in, rd_en, rd_addr,
    input  rd_data, rd_valid, busy, done
  );

  modport slave (
    input  instruction_valid, instruction, activate, data_in, rd_en, rd_addr,
    output rd_data, rd_valid, busy, done
  );

endinterface

// File: rtl/dpu_result_collector_buffer.sv
// Scratch buffer for captured DPU results: one write port, one synchronous
// read port, read-first on a same-address collision. Kept as its own module
// so it can later be replaced by an SRAM macro.
module dpu_result_buffer #(
  parameter int DATA_W    = 16,
  parameter int N_ENTRIES = 16,
  parameter int AW        = $clog2(N_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o
);

  logic [DATA_W-1:0] mem_q [N_ENTRIES];
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  // Storage array: cleared on reset, written one entry per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port: samples the pre-write contents, holds data when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (rd_en_i) begin
      rd_data_q  <= mem_q[rd_addr_i];
      rd_valid_q <= 1'b1;
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/dpu_result_collector.sv
// DPU result collector: decodes its configuration from the shared resource
// instruction stream and, on activate, samples the DPU result word into a
// local buffer following a start/step/count/delay pattern.
module dpu_result_collector
  import dpu_result_collector_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  dpu_result_collector_if.slave  bus
);

  col_t                   cfg_q;
  col_t                   cfg_d;
  logic [3:0]             work_step_q;
  logic [DELAY_WIDTH-1:0] work_delay_q;
  state_t                 state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [ITER_WIDTH-1:0]  cnt_q;
  logic [DELAY_WIDTH-1:0] dly_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   wr_en_s;
  logic                   cfg_unused_s;

  // Next configuration: replaced only by an instruction addressed to this block.
  always_comb begin
    cfg_d = cfg_q;
    if (bus.instruction_valid && (bus.instruction[OPCODE_H:OPCODE_L] == OPCODE_COL)) begin
      cfg_d = unpack_col(bus.instruction[COL_WIDTH-1:0]);
    end else begin
      cfg_d = cfg_q;
    end
  end

  // Configuration register, writable in any controller state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q <= unpack_col({COL_WIDTH{1'b0}});
    end else begin
      cfg_q <= cfg_d;
    end
  end

  // Reserved bits are stored with the word but carry no meaning here.
  assign cfg_unused_s = ^cfg_q._reserved;

  // Capture controller with registered busy/done; works from a copy of the
  // configuration latched at activation so mid-run writes only affect the next run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      work_step_q  <= 4'd0;
      work_delay_q <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      dly_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.activate) begin
            work_step_q  <= cfg_q._step;
            work_delay_q <= cfg_q._delay;
            addr_q       <= cfg_q._start;
            cnt_q        <= cfg_q._iter;
            dly_q        <= cfg_q._delay;
            busy_q       <= 1'b1;
            state_q      <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (cnt_q == '0) begin
            state_q <= ST_FINISH;
          end else begin
            addr_q <= addr_q + work_step_q;
            cnt_q  <= cnt_q - 1'b1;
            if (work_delay_q != '0) begin
              state_q <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (dly_q == DELAY_WIDTH'(1)) begin
            dly_q   <= work_delay_q;
            state_q <= ST_CAPTURE;
          end else begin
            dly_q <= dly_q - 1'b1;
          end
        end
        ST_FINISH: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign wr_en_s  = (state_q == ST_CAPTURE);
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  dpu_result_buffer #(
    .DATA_W    (BITWIDTH),
    .N_ENTRIES (DEPTH),
    .AW        (ADDR_WIDTH)
  ) u_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wr_en_s),
    .wr_addr_i  (addr_q),
    .wr_data_i  (bus.data_in),
    .rd_en_i    (bus.rd_en),
    .rd_addr_i  (bus.rd_addr),
    .rd_data_o  (bus.rd_data),
    .rd_valid_o (bus.rd_valid)
  );

endmodule

// File: doc/dpu_result_collector.md
Name: dpu_result_collector

Overview:
- Downstream neighbour of the DPU resource. Captures the DPU result word (`word_data_out_0`) into a small local scratch buffer.
- Sampling follows a programmable pattern: start address, step, sample count and inter-sample delay.
- The buffer is then drained by a downstream consumer (IO/streaming unit) through a synchronous read port.
- Configured by the same 27-bit resource instruction stream as the DPU; a capture run is started by `activate`.

Parameters:
- BITWIDTH, 16, width of captured data words.
- DEPTH, 16, buffer entries; power of two.
- ADDR_WIDTH, $clog2(DEPTH) = 4, buffer address width.
- ITER_WIDTH, 6, sample-count field width (count = iter + 1, 1..64).
- DELAY_WIDTH, 3, idle cycles between consecutive samples.
- INSTRUCTION_PAYLOAD_WIDTH, 27, instruction payload width.
- OPCODE_COL, 5, opcode value [26:24] selecting this block.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- instruction_valid  in  1  instruction strobe
- instruction  in  27  payload; opcode in [26:24]
- activate  in  1  start a capture run
- data_in  in  BITWIDTH  DPU result word (unregistered DPU output)
- rd_en  in  1  read request
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  BITWIDTH  read data, valid 1 cycle after rd_en
- rd_valid  out  1  qualifies rd_data
- busy  out  1  capture run in progress
- done  out  1  one-cycle pulse after final sample written

Interface note: one clock `clk`; reset `rst_n` is asynchronous and active-low.

Behaviour:
- **Reset:** all outputs, buffer contents, config registers, counters and the FSM reset to 0; FSM is in IDLE.
  - Reset mid-run aborts the run immediately; no `done` pulse is generated.
- **Config decode:** when `instruction_valid` and opcode == OPCODE_COL, update the config register. Fields, MSB-first after the opcode:
  - `_start` [23:20]
  - `_step` [19:16], unsigned
  - `_iter` [15:10]
  - `_delay` [9:7]
  - [6:0] reserved
  - Config writes are accepted in any state. A running capture uses the working copy latched at activation, so a mid-run config write affects only the next run.
- **FSM states:** IDLE, CAPTURE, GAP, FINISH.
  - IDLE: `activate` = 1 at edge k latches the working copy, sets addr = `_start`, cnt = `_iter` and dly = `_delay`, then moves to CAPTURE. `busy` = 1 from cycle k+1.
  - CAPTURE: write `data_in` to buf[addr] at the next edge.
    - If cnt == 0, go to FINISH.
    - Otherwise set addr <= addr + step (mod DEPTH; wraps silently), cnt <= cnt − 1, and go to GAP if `_delay` != 0, else stay in CAPTURE.
  - GAP: decrement dly each cycle. When dly == 1, reload dly with `_delay` and go to CAPTURE. Exactly `_delay` idle cycles separate two writes.
  - FINISH: `done` = 1 for one cycle, `busy` = 0, return to IDLE.
- **Activate handling:** `activate` is ignored while `busy`; there is no restart and no queueing. `activate` on the same edge as a config write uses the old config.
- **Write latency:** the first sample is the `data_in` present during cycle k+1, written at edge k+2. Run length in cycles is (iter+1) + iter·delay + 1 (FINISH).
- **Read port:**
  - On an edge with `rd_en`, `rd_data` <= buf[`rd_addr`] and `rd_valid` <= 1. Otherwise `rd_valid` <= 0 and `rd_data` holds its value.
  - Read/write to the same address on the same edge returns the old contents (read-first).
  - Reads are permitted while `busy`.
- **Step behaviour:**
  - step = 0 makes every sample overwrite the same entry; the last sample wins.
  - Step and wrap arithmetic is ADDR_WIDTH-bit unsigned.

Decomposition:
- Shared package (`<fingerprint>_pkg`) holds:
  - `col_t` packed struct (`_start`, `_step`, `_iter`, `_delay`, `_reserved`) with `unpack_col`/`pack_col`
  - OPCODE_COL, OPCODE_H/L, BITWIDTH
  - FSM state enum
- Sub-module `dpu_result_buffer`: DEPTH×BITWIDTH single-write/single-read synchronous read-first memory, reset to 0. Allows a later swap to an SRAM macro.
- The controller FSM stays in the top module.

Test Plan:
- **Basic run:** config start=2, step=1, iter=3, delay=0; activate; `data_in` 10,20,30,40 on consecutive cycles → buf[2..5] = 10,20,30,40; `done` 6 cycles after activate edge; `busy` high for cycles k+1..k+5.
- **Gap and wrap:** start=14, step=3, iter=2, delay=2; `data_in` counter incrementing each cycle from 0 at cycle k+1 → writes 0@14, 3@1, 6@4; `done` at cycle k+9.
- **Busy protections:** activate pulsed mid-run and an OPCODE_COL write mid-run → run unchanged; a second activate after `done` uses the new config.
- **Read collision:** rd_en with rd_addr=5 on the same edge buf[5] is written 99 (was 7) → `rd_data` = 7, `rd_valid` = 1; next read → 99.
- **Non-matching opcode:** instruction with opcode=3 (DPU) → config unchanged and no activity.
- **Reset mid-run:** assert `rst_n` = 0 during GAP → `busy`, `done`, `rd_valid` and `rd_data` = 0 immediately, buffer cleared, FSM in IDLE; a new run then behaves as in the basic-run scenario.
